// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller after the byte UART receiver: parses SYNC/ADDR/LEN/payload/CHK,
// buffers the payload and drains it to a register-bank write port once the checksum matches.
// Optional frame statistics counters are enabled with `define UART_RX_FRAME_STATS_EN.
module uart_rx_frame_ctrl #(
    parameter int         CLK_FRE    = 50,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 16,
    parameter int         TIMEOUT_US = 1000,
    parameter int         ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_valid,
    output logic              rx_data_ready,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
`ifdef UART_RX_FRAME_STATS_EN
    ,
    output logic [15:0]       frame_ok_cnt,
    output logic [15:0]       frame_err_cnt
`endif
);

    localparam int TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;
    localparam int TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int IDX_W       = $clog2(MAX_LEN + 1);
    localparam int BUF_AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_addr;
    logic [IDX_W-1:0]  len;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  k;
    logic [7:0]        sum;
    logic [7:0]        chk_sum;
    logic [TO_W-1:0]   gap;
    logic [7:0]        pay_buf [MAX_LEN];

    logic       accept;
    logic       in_frame;
    logic       timed_out;
    logic       wr_fire;
    logic       last_wr;
    logic       set_done;
    logic       set_err;
    logic [1:0] err_nx;

    assign accept    = rx_data_valid && rx_data_ready;
    assign in_frame  = state inside {S_ADDR, S_LEN, S_PAYLOAD, S_CHK};
    assign timed_out = in_frame && (gap == TO_W'(TIMEOUT_CYC - 1));
    assign wr_fire   = (state == S_DRAIN) && wr_ready;
    assign last_wr   = wr_fire && (k == len - 1'b1);
    assign chk_sum   = sum + rx_data;

    assign busy    = (state != S_IDLE);
    assign wr_en   = (state == S_DRAIN);
    assign wr_addr = wr_en ? base_addr + ADDR_W'(k) : '0;
    assign wr_data = wr_en ? pay_buf[k[BUF_AW-1:0]] : 8'h00;

    // Timeout outranks whatever byte arrives in the same cycle.
    always_comb begin
        state_nx = state;
        set_done = 1'b0;
        set_err  = 1'b0;
        err_nx   = err_code;
        if (timed_out) begin
            state_nx = S_IDLE;
            set_err  = 1'b1;
            err_nx   = 2'd3;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept && rx_data == SYNC_BYTE)
                        state_nx = S_ADDR;
                end
                S_ADDR: begin
                    if (accept)
                        state_nx = S_LEN;
                end
                S_LEN: begin
                    if (accept) begin
                        if (int'(rx_data) > MAX_LEN) begin
                            state_nx = S_IDLE;
                            set_err  = 1'b1;
                            err_nx   = 2'd2;
                        end else if (rx_data == 8'h00) begin
                            state_nx = S_CHK;
                        end else begin
                            state_nx = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (accept && idx == len - 1'b1)
                        state_nx = S_CHK;
                end
                S_CHK: begin
                    if (accept) begin
                        if (chk_sum != 8'h00) begin
                            state_nx = S_IDLE;
                            set_err  = 1'b1;
                            err_nx   = 2'd1;
                        end else if (len == '0) begin
                            state_nx = S_IDLE;
                            set_done = 1'b1;
                        end else begin
                            state_nx = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_wr) begin
                        state_nx = S_IDLE;
                        set_done = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rx_data_ready <= 1'b0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            err_code      <= 2'd0;
            base_addr     <= '0;
            len           <= '0;
            idx           <= '0;
            k             <= '0;
            sum           <= 8'h00;
            gap           <= '0;
        end else begin
            state         <= state_nx;
            rx_data_ready <= (state_nx != S_DRAIN);
            frame_done    <= set_done;
            frame_err     <= set_err;
            err_code      <= err_nx;

            if (!in_frame || accept || timed_out)
                gap <= '0;
            else
                gap <= gap + 1'b1;

            if (accept && !timed_out) begin
                case (state)
                    S_IDLE: begin
                        idx <= '0;
                        k   <= '0;
                    end
                    S_ADDR: begin
                        base_addr <= ADDR_W'(rx_data);
                        sum       <= rx_data;
                    end
                    S_LEN: begin
                        len <= IDX_W'(rx_data);
                        sum <= chk_sum;
                    end
                    S_PAYLOAD: begin
                        idx <= idx + 1'b1;
                        sum <= chk_sum;
                    end
                    default: ;
                endcase
            end

            if (wr_fire)
                k <= k + 1'b1;
        end
    end

    // Payload storage has no reset; a reset abandons its contents by returning to S_IDLE.
    always_ff @(posedge clk) begin
        if (!rst && accept && !timed_out && state == S_PAYLOAD)
            pay_buf[idx[BUF_AW-1:0]] <= rx_data;
    end

`ifdef UART_RX_FRAME_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok_cnt  <= 16'h0000;
            frame_err_cnt <= 16'h0000;
        end else begin
            if (frame_done && frame_ok_cnt != 16'hFFFF)
                frame_ok_cnt <= frame_ok_cnt + 16'h0001;
            if (frame_err && frame_err_cnt != 16'hFFFF)
                frame_err_cnt <= frame_err_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: expected writes and frame events are queued
// when frames are sent and compared by a monitor as the DUT produces them.
module tb_uart_rx_frame_ctrl;

    localparam int CLK_FRE     = 50;
    localparam int TIMEOUT_US  = 4;
    localparam int TIMEOUT_CYC = CLK_FRE * TIMEOUT_US;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       wr_en;
    logic       wr_ready;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
`ifdef UART_RX_FRAME_STATS_EN
    logic [15:0] frame_ok_cnt;
    logic [15:0] frame_err_cnt;
`endif

    wr_t exp_q[$];
    int  evt_q[$];
    int  check_cnt = 0;
    int  pass_cnt = 0;
    int  wr_cycles = 0;
    int  exp_err_code = 0;
    int  exp_ok = 0;
    int  exp_errs = 0;

    uart_rx_frame_ctrl #(
        .CLK_FRE    (CLK_FRE),
        .SYNC_BYTE  (8'hA5),
        .MAX_LEN    (16),
        .TIMEOUT_US (TIMEOUT_US),
        .ADDR_W     (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .wr_en         (wr_en),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy)
`ifdef UART_RX_FRAME_STATS_EN
        ,
        .frame_ok_cnt  (frame_ok_cnt),
        .frame_err_cnt (frame_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Presents one byte and holds it until the DUT accepts it on a clock edge.
    task automatic applyStimulus(input logic [7:0] b);
        int n;
        n = 0;
        rx_data       = b;
        rx_data_valid = 1'b1;
        while (!rx_data_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 1000)
            checkOutput("rdy_wait", 0, 1);
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic send_bytes(input byte_q_t bytes);
        foreach (bytes[i])
            applyStimulus(bytes[i]);
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic push_evt(input int e);
        evt_q.push_back(e);
        if (e == 0)
            exp_ok++;
        else
            exp_errs++;
    endtask

    task automatic wait_frames(input int budget);
        int n;
        n = 0;
        while ((evt_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("frames_flushed", evt_q.size() + exp_q.size(), 0);
    endtask

    // Monitor: compares writes and frame events against the scoreboard queues.
    always @(negedge clk) begin
        int e;
        if (!rst) begin
            if (wr_en) begin
                wr_cycles++;
                checkOutput("rdy_in_drain", rx_data_ready, 0);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_wr", 1, 0);
                end else begin
                    checkOutput("wr_addr", wr_addr, exp_q[0].addr);
                    checkOutput("wr_data", wr_data, exp_q[0].data);
                    if (wr_ready)
                        void'(exp_q.pop_front());
                end
            end
            if (frame_done || frame_err) begin
                checkOutput("done_err_excl", frame_done && frame_err, 0);
                if (evt_q.size() == 0) begin
                    checkOutput("unexpected_evt", 1, 0);
                end else begin
                    e = evt_q.pop_front();
                    checkOutput("evt_kind", frame_err ? {30'd0, err_code} : 32'd0, e);
                    if (e != 0)
                        exp_err_code = e;
                    else
                        checkOutput("err_code_hold", err_code, exp_err_code);
                end
            end
        end
    end

    initial begin
        byte_q_t fr;
        int      n;
        int      wr_base;

        rst           = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        wr_ready      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", rx_data_ready, 0);
        checkOutput("rst_wr_en", wr_en, 0);
        checkOutput("rst_done", frame_done, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_err_code", err_code, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready_after_rst", rx_data_ready, 1);

        $display("[TB] good frame");
        wr_base = wr_cycles;
        push_wr(8'h10, 8'h11);
        push_wr(8'h11, 8'h22);
        push_wr(8'h12, 8'h33);
        push_evt(0);
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
        send_bytes(fr);
        wait_frames(50);
        checkOutput("good_wr_cycles", wr_cycles - wr_base, 3);
        checkOutput("good_err_code", err_code, 0);
        checkOutput("good_busy", busy, 0);

        $display("[TB] bad checksum");
        wr_base = wr_cycles;
        push_evt(1);
        fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
        send_bytes(fr);
        wait_frames(50);
        checkOutput("chk_no_wr", wr_cycles - wr_base, 0);
        checkOutput("chk_err_code", err_code, 1);
        checkOutput("chk_busy", busy, 0);

        $display("[TB] length overflow");
        push_evt(2);
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        applyStimulus(8'h11);
        checkOutput("len_err_pulse", frame_err, 1);
        checkOutput("len_err_code", err_code, 2);
        wait_frames(20);
        applyStimulus(8'h00);
        checkOutput("len_ignore0_busy", busy, 0);
        applyStimulus(8'h00);
        checkOutput("len_ignore1_busy", busy, 0);

        $display("[TB] timeout");
        push_evt(3);
        applyStimulus(8'hA5);
        applyStimulus(8'h10);
        n = 0;
        while (!frame_err && n < TIMEOUT_CYC + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("timeout_cycles", n, TIMEOUT_CYC);
        checkOutput("timeout_err_code", err_code, 3);
        checkOutput("timeout_busy", busy, 0);
        wait_frames(20);
        push_wr(8'h20, 8'h55);
        push_evt(0);
        fr = '{8'hA5, 8'h20, 8'h01, 8'h55, 8'h8A};
        send_bytes(fr);
        wait_frames(50);

        $display("[TB] drain stall and address wrap");
        wr_base  = wr_cycles;
        wr_ready = 1'b0;
        push_wr(8'hFF, 8'h01);
        push_wr(8'h00, 8'h02);
        push_evt(0);
        fr = '{8'hA5, 8'hFF, 8'h02, 8'h01, 8'h02, 8'hFC};
        send_bytes(fr);
        checkOutput("stall_wr_en", wr_en, 1);
        checkOutput("stall_ready", rx_data_ready, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        wait_frames(50);
        checkOutput("stall_wr_cycles", wr_cycles - wr_base, 7);

        $display("[TB] noise then empty frame");
        wr_base = wr_cycles;
        push_evt(0);
        fr = '{8'h00, 8'h5A, 8'h13, 8'hA5, 8'h30, 8'h00, 8'hD0};
        send_bytes(fr);
        wait_frames(50);
        checkOutput("empty_no_wr", wr_cycles - wr_base, 0);
        repeat (2) @(posedge clk);
        #1;
`ifdef UART_RX_FRAME_STATS_EN
        checkOutput("stats_ok", frame_ok_cnt, exp_ok);
        checkOutput("stats_err", frame_err_cnt, exp_errs);
`endif
        checkOutput("final_busy", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Frame-level controller placed after the byte-level UART receiver.
- Owns the receiver's rx_data/rx_data_valid/rx_data_ready handshake and parses frames of the form SYNC, ADDR, LEN, payload, CHK.
- Buffers the payload and commits it to a register-bank write port only after the checksum verifies.
- Reports frame completion and error pulses to the host logic.

Parameters:
- CLK_FRE, 50, clock frequency in MHz.
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; sets the buffer depth.
- TIMEOUT_US, 1000, maximum gap between accepted bytes inside a frame, in microseconds.
- ADDR_W, 8, width of the write address.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_data  input  8  byte from the UART receiver
- rx_data_valid  input  1  byte available
- rx_data_ready  output  1  controller accepts the byte
- wr_en  output  1  register write request
- wr_ready  input  1  register bank accepts the write
- wr_addr  output  ADDR_W  write address
- wr_data  output  8  write data
- frame_done  output  1  one-cycle pulse: frame committed
- frame_err  output  1  one-cycle pulse: frame dropped
- err_code  output  2  cause of the last error: 1 checksum, 2 length, 3 timeout; held until the next frame_err
- busy  output  1  high in every state except S_IDLE

Behaviour:
- Accept: a byte is consumed on a cycle where rx_data_valid && rx_data_ready.
- rx_data_ready is a registered output. It is 1 in S_IDLE, S_ADDR, S_LEN, S_PAYLOAD and S_CHK, and 0 in S_DRAIN and during reset.
- Reset: all outputs are 0, state is S_IDLE, counters and checksum are cleared.
  - A reset mid-frame or mid-drain discards the buffer.
  - No wr_en is asserted after reset is sampled.
- S_IDLE: an accepted byte equal to SYNC_BYTE moves to S_ADDR. Any other byte is consumed and ignored.
- S_ADDR: the accepted byte is latched as the base address (zero-extended to ADDR_W) and loaded into the checksum; move to S_LEN.
- S_LEN: the accepted byte is added to the checksum.
  - LEN > MAX_LEN: frame_err pulses, err_code becomes 2, return to S_IDLE.
  - LEN == 0: move to S_CHK.
  - Otherwise: move to S_PAYLOAD.
- S_PAYLOAD: each accepted byte is stored at buf[idx] and added to the checksum; idx increments. After LEN bytes, move to S_CHK.
- S_CHK: accepted byte plus the running sum, mod 256, must equal 0.
  - Pass with LEN > 0: move to S_DRAIN.
  - Pass with LEN == 0: frame_done pulses and return to S_IDLE.
  - Fail: frame_err pulses, err_code becomes 1, return to S_IDLE.
- S_DRAIN: wr_en=1 with wr_addr = base + k (mod 2^ADDR_W) and wr_data = buf[k].
  - wr_addr and wr_data are stable while wr_en && !wr_ready.
  - k advances on wr_en && wr_ready.
  - The write of the last byte being accepted pulses frame_done on the next cycle and returns to S_IDLE with wr_en=0.
- Timeout: TIMEOUT_CYC = CLK_FRE*TIMEOUT_US.
  - A gap counter runs in S_ADDR..S_CHK and clears on each accepted byte.
  - When it reaches TIMEOUT_CYC-1: frame_err pulses, err_code becomes 3, return to S_IDLE.
  - Timeout takes priority over a byte accepted in the same cycle; that byte is discarded.
  - The counter does not run in S_IDLE or S_DRAIN.
- Width rules: checksum is 8-bit wrapping. idx and k are $clog2(MAX_LEN+1) bits.
- frame_done and frame_err never assert in the same cycle.

Optional Feature:
- Macro: UART_RX_FRAME_STATS_EN.
- When defined, two extra outputs are added:
  - frame_ok_cnt [15:0]: increments on each frame_done.
  - frame_err_cnt [15:0]: increments on each frame_err.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and counters are absent and the behaviour is otherwise identical.

Test Plan:
- Good frame A5 10 03 11 22 33 87, wr_ready=1: writes (10,11), (11,22), (12,33) on consecutive cycles; then frame_done=1, err_code unchanged.
- Same frame with CHK=88: no wr_en; frame_err pulses, err_code=1, busy returns to 0.
- A5 10 11 (LEN=17, MAX_LEN=16): frame_err and err_code=2 right after the LEN byte; subsequent 00 bytes are ignored until A5.
- A5 10 then silence for TIMEOUT_CYC cycles: frame_err pulses, err_code=3, state S_IDLE; a following good frame is processed normally.
- Good frame A5 FF 02 01 02 FC with wr_ready low for the first 5 drain cycles: wr_en held with wr_addr=FF, wr_data=01 stable; then writes (FF,01), (00,02) (address wrap), rx_data_ready=0 throughout the drain.
- Noise 00 5A 13 before A5 30 00 D0: noise is ignored, frame_done pulses with zero writes; with UART_RX_FRAME_STATS_EN defined, frame_ok_cnt=1.
